tlp_class_scheduler: RTL

//  Sits downstream of the PCIe packet detector. Takes each detected 160-bit TLP with its
//  one-hot type flags and sorts it into one of three class queues: Posted, Non-Posted or

---
 rtl/tlp_class_scheduler_if.sv | 23 ++
 rtl/tlp_class_scheduler.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/tlp_class_scheduler_if.sv
// Handshake bundle for tlp_class_scheduler: detected-TLP input strobe and
// registered valid/ready output stream.
interface tlp_class_scheduler_if #(
  parameter int OUT_PKT_WIDTH = 160
);
  logic                     pkt_valid;
  logic [OUT_PKT_WIDTH-1:0] pkt_in;
  logic [9:0]               pkt_type;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_PKT_WIDTH-1:0] out_pkt;
  logic [1:0]               out_class;

  modport master (
    output pkt_valid, pkt_in, pkt_type, out_ready,
    input  out_valid, out_pkt, out_class
  );

  modport slave (
    input  pkt_valid, pkt_in, pkt_type, out_ready,
    output out_valid, out_pkt, out_class
  );
endinterface

// File: rtl/tlp_class_scheduler.sv
// Sorts detected TLPs into Posted / Non-Posted / Completion queues and drains them
// through one registered output. Optional macro CPL_PRIORITY_EN: CPL > rr(P, NP).
module tlp_class_scheduler #(
  parameter int OUT_PKT_WIDTH = 160,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  tlp_class_scheduler_if.slave          bus,
  output logic [$clog2(FIFO_DEPTH):0]   occ_p,
  output logic [$clog2(FIFO_DEPTH):0]   occ_np,
  output logic [$clog2(FIFO_DEPTH):0]   occ_cpl,
  output logic [CNT_WIDTH-1:0]          drop_cnt,
  output logic [CNT_WIDTH-1:0]          err_cnt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [1:0] CLS_P   = 2'd0;
  localparam logic [1:0] CLS_NP  = 2'd1;
  localparam logic [1:0] CLS_CPL = 2'd2;

  logic                     type_ok;
  logic [1:0]               in_class;
  logic [2:0]               non_empty;
  logic [2:0]               full;
  logic [2:0]               push;
  logic [2:0]               pop;
  logic [OUT_PKT_WIDTH-1:0] head [3];
  logic [PTR_W:0]           occ  [3];
  logic                     load;
  logic                     have_win;
  logic [1:0]               win;
  logic [2:0]               cand;
  logic                     drop;

  logic                     out_valid_reg;
  logic [OUT_PKT_WIDTH-1:0] out_pkt_reg;
  logic [1:0]               out_class_reg;
  logic [1:0]               rr_ptr_reg, rr_ptr_next;
  logic [CNT_WIDTH-1:0]     drop_cnt_reg, err_cnt_reg;

  always_comb begin
    type_ok = (bus.pkt_type != '0) && ((bus.pkt_type & (bus.pkt_type - 10'd1)) == '0);
    if (bus.pkt_type[8])
      in_class = CLS_P;
    else if (|bus.pkt_type[1:0])
      in_class = CLS_CPL;
    else
      in_class = CLS_NP;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_q
    logic [OUT_PKT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]           occ_reg;

    assign non_empty[gi] = (occ_reg != '0);
    assign full[gi]      = (occ_reg == DEPTH_V);
    assign pop[gi]       = load && have_win && (win == 2'(gi));
    // A full queue still accepts when its head leaves on the same edge.
    assign push[gi]      = bus.pkt_valid && type_ok && (in_class == 2'(gi)) &&
                           (!full[gi] || pop[gi]);
    assign head[gi]      = mem[rd_ptr_reg];
    assign occ[gi]       = occ_reg;

    always_ff @(posedge clk) begin
      if (push[gi])
        mem[wr_ptr_reg] <= bus.pkt_in;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        occ_reg    <= '0;
      end else begin
        if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        occ_reg <= occ_reg + (PTR_W+1)'(push[gi]) - (PTR_W+1)'(pop[gi]);
      end
    end
  end

  always_comb begin
    load        = !out_valid_reg || bus.out_ready;
    have_win    = 1'b0;
    win         = CLS_P;
    cand        = '0;
    rr_ptr_next = rr_ptr_reg;
`ifdef CPL_PRIORITY_EN
    if (non_empty[CLS_CPL]) begin
      have_win = 1'b1;
      win      = CLS_CPL;
    end else if (non_empty[rr_ptr_reg[0]]) begin
      have_win = 1'b1;
      win      = {1'b0, rr_ptr_reg[0]};
    end else if (non_empty[~rr_ptr_reg[0]]) begin
      have_win = 1'b1;
      win      = {1'b0, ~rr_ptr_reg[0]};
    end
    // CPL wins leave the P/NP rotation untouched.
    if (load && have_win && (win != CLS_CPL))
      rr_ptr_next = {1'b0, ~win[0]};
`else
    for (int i = 0; i < 3; i++) begin
      cand = {1'b0, rr_ptr_reg} + 3'(i);
      if (cand > 3'd2) cand = cand - 3'd3;
      if (!have_win && non_empty[cand[1:0]]) begin
        have_win = 1'b1;
        win      = cand[1:0];
      end
    end
    if (load && have_win)
      rr_ptr_next = (win == CLS_CPL) ? CLS_P : win + 2'd1;
`endif
    drop = bus.pkt_valid && type_ok && full[in_class] && !pop[in_class];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
      out_pkt_reg   <= '0;
      out_class_reg <= CLS_P;
      rr_ptr_reg    <= CLS_P;
      drop_cnt_reg  <= '0;
      err_cnt_reg   <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      if (load) begin
        out_valid_reg <= have_win;
        if (have_win) begin
          out_pkt_reg   <= head[win];
          out_class_reg <= win;
        end
      end
      if (drop && (drop_cnt_reg != '1))
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
      if (bus.pkt_valid && !type_ok && (err_cnt_reg != '1))
        err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_pkt   = out_pkt_reg;
  assign bus.out_class = out_class_reg;
  assign occ_p         = occ[CLS_P];
  assign occ_np        = occ[CLS_NP];
  assign occ_cpl       = occ[CLS_CPL];
  assign drop_cnt      = drop_cnt_reg;
  assign err_cnt       = err_cnt_reg;
endmodule
